instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the instruction ROM: owns the PC, drives rom_addr, captures rom_rdata
//  into a small prefetch buffer and hands {pc, instruction} to decode over valid/ready.
//  Sits between the instruction ROM (async read, word index = addr[31:2]) and the decoder.
//  Handles decoder stall, branch/jump redirect (flush) and end-of-ROM stop.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  DEPTH      2              prefetch buffer entries; power of 2, >= 2
//  ROM_WORDS  16             ROM size in words; fetch limit = ROM_WORDS*4
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  rom_addr     out  32  ROM byte address; always equals pc register
//  rom_rdata    in   32  ROM read data, valid combinationally for rom_addr
//  instr_valid  out  1   buffer head valid
//  instr_ready  in   1   decoder accepts head
//  instr_code   out  32  head instruction word; 0 when empty
//  instr_pc     out  32  head instruction address; 0 when empty
//  redirect     in   1   branch/jump taken; flush and load redirect_pc
//  redirect_pc  in   32  redirect target byte address
//  rom_end      out  1   pc >= ROM_WORDS*4; fetch stopped
//  level        out  $clog2(DEPTH+1)  buffer occupancy
//  misalign_err out  1   sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation): pc=RESET_PC, buffer empty, level=0,
//    instr_valid=0, instr_code=0, instr_pc=0, misalign_err=0; rom_end = (RESET_PC >= limit).
//  - pop  = instr_valid & instr_ready.
//  - push = !redirect & !rom_end & !misalign_err & (level < DEPTH | pop); pushes {pc, rom_rdata}
//    at the edge and pc <= pc + 4 (32-bit modulo add).
//  - Push and pop in same cycle allowed at any level incl. full: level unchanged.
//  - Full and no pop: no push, pc and rom_addr hold.
//  - Throughput 1 instr/cycle with ready held high; first instr_valid after first edge
//    following reset release (pc = RESET_PC).
//  - redirect (highest priority): at edge, buffer cleared, level=0, pc <= target, no push.
//    A pop coinciding with redirect completes (decoder owns that instr) but buffer still flushed.
//    Latency: redirect sampled edge k -> rom_addr=target after k -> target instr valid after k+1
//    (exactly one bubble cycle).
//  - End of ROM: pc reaching limit stops pushes; buffer drains normally; rom_end=1 until redirect
//    to in-range target. Redirect to out-of-range target: pc loaded, rom_end=1, no fetch.
//  - Buffer: circular, rd/wr pointers wrap at DEPTH; order strictly preserved, no dup/drop.
//  - instr_code/instr_pc driven from head entry, forced 0 when level==0.
// CONFIGURATION
//  IFETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 flushes buffer, does NOT
//    load pc, sets misalign_err (sticky until reset); all further pushes blocked.
//  Not defined: pc <= {redirect_pc[31:2], 2'b00}; misalign_err tied 0.
// TESTING
//  1 ROM[0]=32'h0011_0233 (add x4,x2,x1), ROM[1]=32'h4011_02B3 (sub x5,x2,x1), ready=1, release
//    reset -> cycle1 valid code 0x00110233 pc 0x0; cycle2 code 0x401102B3 pc 0x4.
//  2 ready=0 for 5 cycles after reset -> level saturates 2, rom_addr holds 0x8, head pc 0x0;
//    ready=1 -> pcs 0x0,0x4,0x8,0xC back-to-back, no gap/dup.
//  3 Buffer full, redirect=1 redirect_pc=0x20 (with pop same cycle) -> level=0, valid low one
//    cycle, then pc 0x20 with ROM[8]; popped instr counted once.
//  4 Run free from 0 -> last delivered pc 0x3C, rom_end=1, rom_addr stays 0x40, valid drops after
//    drain; redirect to 0x0 -> rom_end=0, fetch resumes.
//  5 Assert reset_n=0 mid-stream between edges -> all outputs reset values immediately; release
//    -> restarts at RESET_PC.
//  6 redirect_pc=0x22: macro on -> misalign_err=1, no valid thereafter; macro off -> fetch 0x20.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl_if
//   Bundles the two buses that the fetch sequencer sits between:
//   - instruction ROM side : rom_addr (byte address), rom_rdata (async read data)
//   - decoder side         : instr_valid/instr_ready handshake carrying
//                            instr_code/instr_pc, plus the redirect request
//                            (redirect, redirect_pc) coming back from execute.
//   Modports:
//     master - the fetch controller (drives address, head entry, valid)
//     slave  - the environment (ROM + decoder/redirect source)
// ---------------------------------------------------------------------------
interface instr_fetch_ctrl_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output rom_addr,
    input  rom_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_code,
    output instr_pc,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  rom_addr,
    output rom_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_code,
    input  instr_pc,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch sequencer for the instruction ROM. Owns the PC, presents it as the
//   ROM address, captures the combinational ROM data into a small circular
//   prefetch buffer and hands {pc, instruction} to the decoder over a
//   valid/ready handshake. Handles decoder stall, branch/jump redirect
//   (buffer flush) and stopping at the end of the ROM.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   DEPTH      prefetch buffer entries (power of 2, >= 2)
//   ROM_WORDS  ROM size in words; fetching stops once pc >= ROM_WORDS*4
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   bus          if   instr_fetch_ctrl_if.master (ROM bus, decoder handshake,
//                     redirect request)
//   rom_end      out  pc is at/after the end of the ROM, fetch stopped
//   level        out  prefetch buffer occupancy
//   misalign_err out  sticky misaligned-redirect flag
//
// Build option
//   IFETCH_MISALIGN_TRAP_EN : when defined, a redirect to a non-word-aligned
//   target flushes the buffer, leaves the PC untouched and sets the sticky
//   misalign_err, which blocks all further fetches until reset. When not
//   defined the target is silently word-aligned and misalign_err is tied 0.
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          ROM_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  instr_fetch_ctrl_if.master           bus,
  output logic                         rom_end,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         misalign_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [31:0]   PC_LIMIT   = 32'(ROM_WORDS * 4);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [31:0]   pc_q,     pc_d;
  logic [LW-1:0] level_q,  level_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_code_q [DEPTH];

  logic          buf_empty;
  logic          pop;
  logic          push;
  logic          redirect_bad;

  // Misalignment handling: either a sticky trap flag, or plain word alignment
  // of the redirect target (the low address bits are then don't-care).
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00);
  assign misalign_d   = misalign_q | (bus.redirect & redirect_bad);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
  assign redirect_bad         = 1'b0;
  assign misalign_err         = 1'b0;
`endif

  // The ROM is addressed directly by the PC register; the head of the
  // buffer is presented to the decoder and forced to zero when empty.
  assign buf_empty       = (level_q == '0);
  assign rom_end         = (pc_q >= PC_LIMIT);
  assign level           = level_q;
  assign bus.rom_addr    = pc_q;
  assign bus.instr_valid = !buf_empty;
  assign bus.instr_code  = buf_empty ? 32'h0 : buf_code_q[rd_ptr_q];
  assign bus.instr_pc    = buf_empty ? 32'h0 : buf_pc_q[rd_ptr_q];

  // A push is allowed into a full buffer when the head leaves in the same
  // cycle, which is what sustains one instruction per cycle.
  assign pop  = bus.instr_valid & bus.instr_ready;
  assign push = !bus.redirect & !rom_end & !misalign_err &
                ((level_q < LEVEL_FULL) | pop);

  // Next-state for PC, pointers and occupancy. A redirect wins over
  // everything: the buffer is emptied even if the head is popped this cycle
  // (the decoder keeps that instruction), and nothing is fetched.
  always_comb begin
    pc_d     = pc_q;
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (!redirect_bad) begin
        pc_d = {bus.redirect_pc[31:2], 2'b00};
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        pc_d     = pc_q + 32'd4;
      end
      if (push && !pop) begin
        level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LEVEL_ONE;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      level_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      level_q  <= level_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted
  // in level, and the outputs are forced to zero when it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= pc_q;
      buf_code_q[wr_ptr_q] <= bus.rom_rdata;
    end
  end

endmodule
